// File: rtl/prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// prog_mem_pkg
// Shared types and helpers for the program memory controller.
//   ld_state_e : loader FSM states
//   nbytes()   : number of load bytes needed to build one IW-bit word
// -----------------------------------------------------------------------------
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ld_state_e;

    function automatic int nbytes(input int iw);
        return (iw + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// -----------------------------------------------------------------------------
// prog_mem_if
// Bus bundle between the boot/debug link + core fetch stage (master) and the
// program memory controller (slave).
//   Fetch : rd_en, rd_addr -> rd_data, rd_valid, rd_perr
//   Load  : ld_start, ld_base, ld_len, ld_valid, ld_byte -> ld_ready,
//           ld_busy, ld_done
// Optional macro PROG_MEM_PARITY_EN adds the ld_perr_inj test input.
// -----------------------------------------------------------------------------
interface prog_mem_if #(
    parameter int IW = 12,
    parameter int AW = 8
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_perr;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
`ifdef PROG_MEM_PARITY_EN
    logic          ld_perr_inj;
`endif

    modport master (
        output rd_en, rd_addr, ld_start, ld_base, ld_len, ld_valid, ld_byte,
`ifdef PROG_MEM_PARITY_EN
        output ld_perr_inj,
`endif
        input  rd_data, rd_valid, rd_perr, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  rd_en, rd_addr, ld_start, ld_base, ld_len, ld_valid, ld_byte,
`ifdef PROG_MEM_PARITY_EN
        input  ld_perr_inj,
`endif
        output rd_data, rd_valid, rd_perr, ld_ready, ld_busy, ld_done
    );

endinterface

// File: rtl/prog_mem_loader.sv
// -----------------------------------------------------------------------------
// prog_mem_loader
// Byte-stream loader: assembles little-endian bytes into IW-bit words and
// issues one write per word to consecutive (wrapping) addresses.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   i_start            : load start pulse (honoured only in IDLE)
//   i_base, i_len      : first address / word count, sampled on i_start
//   i_valid, i_byte    : byte stream, accepted when o_ready is high
//   o_ready            : byte accepted this cycle (COLLECT)
//   o_busy, o_done     : load in progress / one-cycle completion pulse
//   o_wr_en, o_wr_addr, o_wr_data : memory write port
// -----------------------------------------------------------------------------
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_len,
    input  logic          i_valid,
    input  logic [7:0]    i_byte,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [IW-1:0] o_wr_data
);

    localparam int NB = nbytes(IW);
    // IW <= 32 gives at most 4 bytes per word, so 2 index bits suffice.
    localparam int IDXW = 2;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

    ld_state_e       r_state;
    ld_state_e       w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW:0]     r_cnt;
    logic [IDXW-1:0] r_idx;
    logic [IW-1:0]   r_word;
    logic [IW-1:0]   w_word_nxt;
    logic            w_accept;

    assign w_accept = i_valid && (r_state == ST_COLLECT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept && (r_idx == LAST_IDX)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // r_cnt still holds the pre-decrement count here.
                w_state_nxt = (r_cnt == (AW+1)'(1)) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_ready = (r_state == ST_COLLECT);
        o_busy  = (r_state != ST_IDLE);
        o_done  = (r_state == ST_DONE);
        o_wr_en = (r_state == ST_WRITE);
    end

    // Byte k lands in bits [8k+7:8k]; bits at or above IW are simply dropped.
    always_comb begin
        w_word_nxt = r_word;
        for (int i = 0; i < IW; i++) begin
            if (r_idx == IDXW'(i / 8)) begin
                w_word_nxt[i] = i_byte[3'(i % 8)];
            end
        end
    end

    // Datapath registers: loaded on start, so a reset needs no clearing here.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && i_start) begin
            r_ptr <= i_base;
            r_cnt <= i_len;
            r_idx <= '0;
        end
        if (w_accept) begin
            r_word <= w_word_nxt;
            r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        if (r_state == ST_WRITE) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_wr_addr = r_ptr;
    assign o_wr_data = r_word;

endmodule

// File: rtl/prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// prog_mem_ctrl
// Program memory (2**AW x IW) with a registered fetch port and a byte-stream
// loader. Fetches are blocked while a load is in progress.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : prog_mem_if.slave (fetch port + loader handshake)
// Optional macro PROG_MEM_PARITY_EN: stores an even-parity bit per word and
// flags mismatches on rd_perr; ld_perr_inj corrupts the stored bit on write.
// Without it, rd_perr is tied to 0.
// -----------------------------------------------------------------------------
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic      clk,
    input  logic      rst,
    prog_mem_if.slave bus
);

    localparam int DEPTH = 2 ** AW;

    logic [IW-1:0] r_mem [DEPTH];
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [IW-1:0] w_wr_data;
    logic          w_ld_busy;
    logic [IW-1:0] r_rd_data_p1;
    logic          r_rd_valid_p1;

    prog_mem_loader #(
        .IW (IW),
        .AW (AW)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .i_start   (bus.ld_start),
        .i_base    (bus.ld_base),
        .i_len     (bus.ld_len),
        .i_valid   (bus.ld_valid),
        .i_byte    (bus.ld_byte),
        .o_ready   (bus.ld_ready),
        .o_busy    (w_ld_busy),
        .o_done    (bus.ld_done),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data)
    );

    assign bus.ld_busy = w_ld_busy;

`ifdef PROG_MEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_rd_perr_p1;

    function automatic logic f_even_par(input logic [IW-1:0] w);
        return ^w;
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
            r_par[w_wr_addr] <= f_even_par(w_wr_data) ^ bus.ld_perr_inj;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end
`endif

    // Fetch stage -> p1: one-cycle registered read, held when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid_p1 <= 1'b0;
            r_rd_data_p1  <= '0;
`ifdef PROG_MEM_PARITY_EN
            r_rd_perr_p1  <= 1'b0;
`endif
        end else if (bus.rd_en && !w_ld_busy) begin
            r_rd_valid_p1 <= 1'b1;
            r_rd_data_p1  <= r_mem[bus.rd_addr];
`ifdef PROG_MEM_PARITY_EN
            r_rd_perr_p1  <= (f_even_par(r_mem[bus.rd_addr]) != r_par[bus.rd_addr]);
`endif
        end else begin
            r_rd_valid_p1 <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            r_rd_perr_p1  <= 1'b0;
`endif
        end
    end

    assign bus.rd_data  = r_rd_data_p1;
    assign bus.rd_valid = r_rd_valid_p1;
`ifdef PROG_MEM_PARITY_EN
    assign bus.rd_perr  = r_rd_perr_p1;
`else
    assign bus.rd_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_ctrl
// Directed bench for prog_mem_ctrl (IW=12, AW=8) with hand-computed words.
// Honours PROG_MEM_PARITY_EN for the parity-injection scenario.
// -----------------------------------------------------------------------------
module tb_prog_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    prog_mem_if #(.IW(12), .AW(8)) bus ();

    prog_mem_ctrl #(.IW(12), .AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic put_byte(input logic [7:0] b, input int gap);
        int n;
        bus.ld_valid = 1'b0;
        repeat (gap) tick();
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        n = 0;
        while (!bus.ld_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.ld_ready) chk("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] len);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        bus.ld_len   = len;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.ld_done && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.ld_done), 32'd1);
        tick();
        chk({tag, "_busy_fall"}, 32'(bus.ld_busy), 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [11:0] exp,
                         input logic perr_exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.rd_data),  32'(exp));
        chk({tag, "_perr"},  32'(bus.rd_perr),  32'(perr_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 8'h00;
        bus.ld_start = 1'b0;
        bus.ld_base  = 8'h00;
        bus.ld_len   = 9'd0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
`ifdef PROG_MEM_PARITY_EN
        bus.ld_perr_inj = 1'b0;
`endif

        // Reset with rd_en held high: nothing may be fetched.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_perr",  32'(bus.rd_perr),  32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_ld_busy",  32'(bus.ld_busy),  32'd0);
        chk("rst_ld_done",  32'(bus.ld_done),  32'd0);
        rst = 1'b0;
        bus.rd_addr = 8'h05;
        tick();
        chk("fetch_after_rst_valid", 32'(bus.rd_valid), 32'd1);
        bus.rd_en = 1'b0;
        tick();
        chk("fetch_idle_valid", 32'(bus.rd_valid), 32'd0);

        // Load two words at 0x10: 0xFABC -> 0xABC, 0x1234 -> 0x234.
        start_load(8'h10, 9'd2);
        chk("start_busy",  32'(bus.ld_busy),  32'd1);
        chk("start_ready", 32'(bus.ld_ready), 32'd1);
        put_byte(8'hBC, 0);
        chk("collect_ready", 32'(bus.ld_ready), 32'd1);
        put_byte(8'hFA, 0);
        chk("write_ready_low", 32'(bus.ld_ready), 32'd0);
        put_byte(8'h34, 0);
        put_byte(8'h12, 0);
        chk("write2_ready_low", 32'(bus.ld_ready), 32'd0);
        tick();
        chk("done_after_last_write", 32'(bus.ld_done), 32'd1);
        chk("done_busy", 32'(bus.ld_busy), 32'd1);
        tick();
        chk("done_pulse_end", 32'(bus.ld_done), 32'd0);
        chk("idle_busy", 32'(bus.ld_busy), 32'd0);
        fetch("rd_10", 8'h10, 12'hABC, 1'b0);
        fetch("rd_11", 8'h11, 12'h234, 1'b0);

        // Back-to-back fetches.
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h11;
        tick();
        chk("b2b0_data", 32'(bus.rd_data), 32'h234);
        bus.rd_addr = 8'h10;
        tick();
        chk("b2b1_data",  32'(bus.rd_data),  32'hABC);
        chk("b2b1_valid", 32'(bus.rd_valid), 32'd1);
        bus.rd_en = 1'b0;

        // Wrap from 0xFF to 0x00 with source stalls.
        start_load(8'hFF, 9'd2);
        put_byte(8'h11, int'($urandom_range(0, 3)));
        put_byte(8'h05, int'($urandom_range(0, 3)));
        chk("wrap_write_ready_low", 32'(bus.ld_ready), 32'd0);
        put_byte(8'h22, int'($urandom_range(0, 3)));
        put_byte(8'h0C, int'($urandom_range(0, 3)));
        wait_done("wrap_done");
        fetch("rd_ff", 8'hFF, 12'h511, 1'b0);
        fetch("rd_00", 8'h00, 12'hC22, 1'b0);

        // Zero-length load, with a fetch in the same cycle as ld_start.
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h11;
        start_load(8'h10, 9'd0);
        bus.rd_en = 1'b0;
        chk("fetch_with_start_valid", 32'(bus.rd_valid), 32'd1);
        chk("fetch_with_start_data",  32'(bus.rd_data),  32'h234);
        chk("len0_done", 32'(bus.ld_done), 32'd1);
        tick();
        chk("len0_done_end", 32'(bus.ld_done), 32'd0);
        chk("len0_busy_end", 32'(bus.ld_busy), 32'd0);
        fetch("len0_no_write", 8'h10, 12'hABC, 1'b0);

        // Second ld_start mid-load is ignored; fetches blocked while loading.
        start_load(8'h20, 9'd1);
        put_byte(8'h66, 0);
        bus.ld_start = 1'b1;
        bus.ld_base  = 8'h30;
        bus.ld_len   = 9'd5;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 8'h10;
        tick();
        bus.ld_start = 1'b0;
        bus.rd_en    = 1'b0;
        chk("fetch_blocked_valid", 32'(bus.rd_valid), 32'd0);
        chk("restart_ignored_ready", 32'(bus.ld_ready), 32'd1);
        put_byte(8'h07, 0);
        tick();
        chk("restart_ignored_done", 32'(bus.ld_done), 32'd1);
        tick();
        chk("restart_ignored_idle", 32'(bus.ld_busy), 32'd0);
        fetch("rd_20", 8'h20, 12'h766, 1'b0);

        // Reset mid-load after one byte of the second word.
        start_load(8'h41, 9'd1);
        put_byte(8'h55, 0);
        put_byte(8'h05, 0);
        wait_done("preload_done");
        start_load(8'h40, 9'd2);
        put_byte(8'h78, 0);
        put_byte(8'h06, 0);
        put_byte(8'h99, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",  32'(bus.ld_busy),  32'd0);
        chk("midrst_ready", 32'(bus.ld_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_done", 32'(bus.ld_done), 32'd0);
            tick();
        end
        fetch("midrst_rd_40", 8'h40, 12'h678, 1'b0);
        fetch("midrst_rd_41", 8'h41, 12'h555, 1'b0);

`ifdef PROG_MEM_PARITY_EN
        // First word written with corrupted parity, second clean.
        bus.ld_perr_inj = 1'b1;
        start_load(8'h50, 9'd2);
        put_byte(8'h0F, 0);
        put_byte(8'h00, 0);
        tick();
        bus.ld_perr_inj = 1'b0;
        put_byte(8'h01, 0);
        put_byte(8'h00, 0);
        wait_done("par_done");
        fetch("par_bad", 8'h50, 12'h00F, 1'b1);
        fetch("par_ok",  8'h51, 12'h001, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
